stopwatch_lap_bcd: RTL and testbench

Parametrised BCD stopwatch with a configurable digit count, a start/stop toggle, lap (split) display hold, clear, and an overflow flag. It divides clk down to a 0.01 s tick and cascades DIGITS decimal counters, with digit 0 holding hundredths. It drives one 7-segment pattern per digit plus a raw BCD bus, and is the drop-in successor for board-level timing displays.

---
 rtl/stopwatch_lap_bcd.sv | 153 +++++++++++++++
 tb/tb_stopwatch_lap_bcd.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_bcd.sv
// BCD stopwatch: prescaled 0.01 s tick, cascaded decimal digits, lap hold, clear, overflow.
// Buttons are synchronised and edge-detected; hex shows the lap snapshot while held.
module stopwatch_lap_bcd #(
  parameter int CLK_DIV        = 260000,
  parameter int DIGITS         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  lap,
  output logic                  running,
  output logic                  held,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);
  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

  state_t              r_state;
  logic                r_running;
  logic                r_held;
  logic                r_overflow;
  logic [PW-1:0]       r_presc;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] r_lap_bcd;
  logic [1:0]          r_ss_sync;
  logic [1:0]          r_lap_sync;
  logic                r_ss_hist;
  logic                r_lap_hist;
  logic [1:0]          r_arm;

  logic                w_ss_pulse;
  logic                w_lap_pulse;
  logic                w_tick;
  logic                w_clear;
  logic [DIGITS-1:0]   w_inc;
  logic                w_wrap;
  logic [4*DIGITS-1:0] w_disp;
  logic [7*DIGITS-1:0] w_hex;

  // History is forced high until the sync chain has refilled, so a button
  // already held at reset release never produces a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ss_sync  <= '0;
      r_lap_sync <= '0;
      r_ss_hist  <= 1'b0;
      r_lap_hist <= 1'b0;
      r_arm      <= '0;
    end else begin
      r_arm      <= {r_arm[0], 1'b1};
      r_ss_sync  <= {r_ss_sync[0], start_stop};
      r_lap_sync <= {r_lap_sync[0], lap};
      r_ss_hist  <= r_ss_sync[1] | ~r_arm[1];
      r_lap_hist <= r_lap_sync[1] | ~r_arm[1];
    end
  end

  assign w_ss_pulse  = r_ss_sync[1] & ~r_ss_hist;
  assign w_lap_pulse = r_lap_sync[1] & ~r_lap_hist;
  assign w_tick      = (r_state == ST_RUNNING) && (r_presc == PW'(CLK_DIV - 1));
  assign w_clear     = w_lap_pulse && !r_held && (r_state == ST_STOPPED);

  // Lap is judged against the state before any same-cycle start/stop toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STOPPED;
      r_running <= 1'b0;
      r_held    <= 1'b0;
      r_lap_bcd <= '0;
    end else begin
      if (w_ss_pulse) begin
        r_state   <= (r_state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
        r_running <= (r_state != ST_RUNNING);
      end
      if (w_lap_pulse) begin
        if (r_held) begin
          r_held <= 1'b0;
        end else if (r_state == ST_RUNNING) begin
          r_held    <= 1'b1;
          r_lap_bcd <= r_bcd;
        end
      end
    end
  end

  always_comb begin : carry_chain
    logic acc;
    acc   = w_tick;
    w_inc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_inc[i] = acc;
      acc      = acc & (r_bcd[4*i +: 4] == 4'd9);
    end
    w_wrap = acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_presc    <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == ST_RUNNING) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (w_inc[i]) begin
          r_bcd[4*i +: 4] <= (r_bcd[4*i +: 4] == 4'd9) ? 4'd0 : r_bcd[4*i +: 4] + 4'd1;
        end
      end
      if (w_wrap) begin
        r_overflow <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg_lo(input logic [3:0] d);
    case (d)
      4'd0:    seg_lo = 7'b0000001;
      4'd1:    seg_lo = 7'b1001111;
      4'd2:    seg_lo = 7'b0010010;
      4'd3:    seg_lo = 7'b0000110;
      4'd4:    seg_lo = 7'b1001100;
      4'd5:    seg_lo = 7'b0100100;
      4'd6:    seg_lo = 7'b0100000;
      4'd7:    seg_lo = 7'b0001111;
      4'd8:    seg_lo = 7'b0000000;
      4'd9:    seg_lo = 7'b0000100;
      default: seg_lo = 7'b1111111;
    endcase
  endfunction

  assign w_disp = r_held ? r_lap_bcd : r_bcd;

  always_comb begin
    w_hex = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_hex[7*i +: 7] = SEG_ACTIVE_LOW ? seg_lo(w_disp[4*i +: 4]) : ~seg_lo(w_disp[4*i +: 4]);
    end
  end

  assign running  = r_running;
  assign held     = r_held;
  assign overflow = r_overflow;
  assign bcd      = r_bcd;
  assign hex      = w_hex;
endmodule

// File: tb/tb_stopwatch_lap_bcd.sv
// Bench for stopwatch_lap_bcd: integer-count model checked every cycle plus literal checkpoints.
module tb_stopwatch_lap_bcd;
  localparam int CLK_DIV = 4;
  localparam int DIGITS  = 4;
  localparam int MAXV    = 9999;
  localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        running, held, overflow;
  logic [15:0] bcd;
  logic [27:0] hex;
  logic        running_h, held_h, overflow_h;
  logic [15:0] bcd_h;
  logic [27:0] hex_h;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_lap_bcd #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap),
    .running(running), .held(held), .overflow(overflow), .bcd(bcd), .hex(hex)
  );

  stopwatch_lap_bcd #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap),
    .running(running_h), .held(held_h), .overflow(overflow_h), .bcd(bcd_h), .hex(hex_h)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] to_hex(input int v);
    logic [27:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = SEG[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  // Model: elapsed count as an integer, button edges from a history of sampled levels.
  int       m_cnt, m_lapv, m_phase, m_edges;
  bit       m_run, m_held, m_ovf;
  bit [2:0] ss_h, lp_h;

  task automatic model_step();
    bit ps, pl, tick;
    int old;
    m_edges++;
    ps   = (m_edges >= 4) && ss_h[1] && !ss_h[2];
    pl   = (m_edges >= 4) && lp_h[1] && !lp_h[2];
    ss_h = {ss_h[1:0], start_stop};
    lp_h = {lp_h[1:0], lap};
    old  = m_cnt;
    tick = m_run && (m_phase == CLK_DIV - 1);
    if (pl && !m_held && !m_run) begin
      m_cnt = 0; m_phase = 0; m_ovf = 0;
    end else if (m_run) begin
      if (tick) begin
        m_phase = 0;
        if (m_cnt == MAXV) begin m_cnt = 0; m_ovf = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        m_phase = m_phase + 1;
      end
    end
    if (pl) begin
      if (m_held) m_held = 0;
      else if (m_run) begin m_held = 1; m_lapv = old; end
    end
    if (ps) m_run = !m_run;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_lapv = 0; m_phase = 0; m_edges = 0;
      m_run = 0; m_held = 0; m_ovf = 0; ss_h = '0; lp_h = '0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    logic [15:0] eb;
    logic [27:0] eh, ehh;
    eb  = to_bcd(m_cnt);
    eh  = to_hex(m_held ? m_lapv : m_cnt);
    ehh = ~eh;
    chk("running", running, m_run);
    chk("held", held, m_held);
    chk("overflow", overflow, m_ovf);
    chk("bcd", bcd, eb);
    chk("hex", hex, eh);
    chk("bcd_hi", bcd_h, eb);
    chk("hex_hi", hex_h, ehh);
  end

  task automatic wait_cnt(input int target, input int budget);
    int k;
    k = 0;
    while (m_cnt != target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_cnt", m_cnt, target);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [27:0] frz;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_running", running, 1'b0);
    chk("rst_bcd", bcd, 16'h0000);
    for (int i = 0; i < DIGITS; i++) chk("rst_hex_digit", hex[7*i +: 7], 7'b0000001);

    edges(4);
    start_stop = 1'b1;
    edges(2);
    chk("run_not_yet", running, 1'b0);
    edges(1);
    chk("run_after_3clk", running, 1'b1);
    start_stop = 1'b0;
    edges(148);
    chk("bcd_0037", bcd, 16'h0037);
    chk("hex0_7", hex[6:0], 7'b0001111);
    chk("hex1_3", hex[13:7], 7'b0000110);
    chk("hex0_7_hi", hex_h[6:0], 7'b1110000);

    wait_cnt(99, 1000);
    edges(3);
    chk("bcd_0099", bcd, 16'h0099);
    edges(1);
    chk("bcd_0100", bcd, 16'h0100);
    chk("ovf_0100", overflow, 1'b0);

    wait_cnt(9999, 50000);
    edges(4);
    chk("bcd_wrap", bcd, 16'h0000);
    chk("ovf_wrap", overflow, 1'b1);
    edges(8);
    chk("bcd_0002", bcd, 16'h0002);
    chk("ovf_sticky", overflow, 1'b1);

    wait_cnt(250, 2000);
    lap = 1'b1;
    edges(3);
    frz = {7'b0000001, 7'b0010010, 7'b0100100, 7'b0000001};
    chk("held_set", held, 1'b1);
    chk("hex_frozen", hex, frz);
    lap = 1'b0;
    edges(40);
    chk("bcd_0260", bcd, 16'h0260);
    chk("hex_still_frozen", hex, frz);
    lap = 1'b1;
    edges(3);
    frz = {7'b0000001, 7'b0010010, 7'b0100000, 7'b1001111};
    chk("held_clr", held, 1'b0);
    chk("bcd_0261", bcd, 16'h0261);
    chk("hex_tracks", hex, frz);
    lap = 1'b0;

    wait_cnt(412, 2000);
    start_stop = 1'b1;
    edges(3);
    chk("stopped", running, 1'b0);
    start_stop = 1'b0;
    edges(100);
    chk("bcd_static", bcd, 16'h0412);
    lap = 1'b1;
    edges(3);
    chk("clear_bcd", bcd, 16'h0000);
    chk("clear_ovf", overflow, 1'b0);
    chk("clear_held", held, 1'b0);
    lap = 1'b0;
    edges(5);
    start_stop = 1'b1;
    edges(3);
    chk("restart", running, 1'b1);
    start_stop = 1'b0;
    edges(3);
    chk("no_tick_yet", bcd, 16'h0000);
    edges(1);
    chk("first_tick", bcd, 16'h0001);

    lap = 1'b1;
    edges(3);
    chk("held_before_rst", held, 1'b1);
    lap = 1'b0;
    edges(10);
    #1 reset = 1'b1;
    start_stop = 1'b1;
    #1;
    chk("arst_running", running_h, 1'b0);
    chk("arst_held", held_h, 1'b0);
    chk("arst_ovf", overflow_h, 1'b0);
    chk("arst_bcd", bcd_h, 16'h0000);
    for (int i = 0; i < DIGITS; i++) chk("arst_hex_hi", hex_h[7*i +: 7], 7'b1111110);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    edges(20);
    chk("no_toggle_held_btn", running, 1'b0);
    start_stop = 1'b0;
    edges(5);
    start_stop = 1'b1;
    edges(3);
    chk("toggle_after_repress", running, 1'b1);
    start_stop = 1'b0;
    edges(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
